vec_alu_sequencer: RTL
======================

// Module: vec_alu_sequencer
// PURPOSE
//  Memory-to-memory vector sequencer wrapped around the 16-bit ALU (ops 0..4).
//  Runs one vector command: dst[i] = srcA[i] OP srcB[i] for i = 0..len-1.
//  Owns the single-port data-memory master and drives the ALU A/B/op inputs
//  combinationally from internal registers. Sits between the instruction-decode
//  stage and data memory.
// PARAMETERS
//  ADDR_W  16  memory word-address width; pointer arithmetic is mod 2^ADDR_W
//  DATA_W  16  element width; must equal the ALU operand width
//  LEN_W   8   vector-length field width; maximum length is 2^LEN_W-1
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       command valid; accepted only when busy=0
//  op         in   4       ALU op: 0 add, 1 sub, 2 and, 3 or, 4 compare
//  base_a     in   ADDR_W  srcA base address
//  base_b     in   ADDR_W  srcB base address
//  base_d     in   ADDR_W  destination base address (ignored for op 4)
//  len        in   LEN_W   element count
//  busy       out  1       high from the accept edge until done is pulsed
//  done       out  1       one-cycle pulse at command completion
//  eq_all     out  1       op 4 only: every compared pair had zero=1
//  mem_req    out  1       memory request valid
//  mem_we     out  1       1 = write, 0 = read; qualified by mem_req
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid in the cycle mem_ready=1
//  mem_ready  in   1       request completes in any cycle with mem_req&mem_ready
//  alu_a      out  DATA_W  to ALU A (registered element A)
//  alu_b      out  DATA_W  to ALU B (registered element B)
//  alu_op     out  4       to ALU op (latched op)
//  alu_out    in   DATA_W  from ALU result
//  alu_zero   in   1       from ALU zero flag (valid for op 4)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, mem_req and mem_we = 0; eq_all = 1;
//   mem_addr, mem_wdata, alu_a, alu_b = 0; alu_op = 0. Reset mid-command
//   aborts immediately with no done pulse; the partial write is not recovered.
//  FSM: IDLE -> RD_A -> RD_B -> EXEC -> WR -> (RD_A | FIN) -> IDLE.
//   IDLE: on start, latch op/bases/len, clear element counter, set eq_all=1,
//    raise busy next edge. len=0 -> FIN directly (no memory access).
//   RD_A/RD_B: hold mem_req=1, mem_we=0 and mem_addr stable until mem_ready;
//    capture mem_rdata into A/B reg on the ready cycle.
//   EXEC: one cycle; latch alu_out into the write-data reg. For op 4, AND
//    alu_zero into eq_all, then skip WR.
//   WR: mem_req=1, mem_we=1, addr=base_d+i; hold until mem_ready.
//   After WR (or EXEC for op 4): i+1==len -> FIN, else i++ and go to RD_A.
//   FIN: done=1 for exactly one cycle, busy=0 on the same edge that returns
//    to IDLE. A start in the FIN cycle is ignored.
//  Latency with zero-wait memory: 4 cycles/element (3 for op 4); total
//   1 + 4*len + 1 cycles from start to done. Each mem_ready=0 cycle adds 1.
//  Addresses: base+i, wrapping mod 2^ADDR_W without error.
//  Ops 5..15: treated as len=0 (done pulse, no access); eq_all unchanged = 1.
//  start while busy: ignored, with no side effects. eq_all holds until the
//   next accepted command.
// CONFIGURATION
//  VSEQ_EARLY_EXIT_EN defined: op 4 goes to FIN on the first pair with
//   alu_zero=0; remaining elements are not read.
//  Not defined: op 4 always reads all len pairs. eq_all is the same either way.
// STRUCTURE
//  vseq_pkg: state encoding localparams, ALU op-code constants (OP_ADD..OP_CMP),
//   and the OP_MAX_VALID constant.
//  One sub-module, vseq_addr_gen: holds base regs and element counter i, and
//   outputs addr_a/addr_b/addr_d and the last flag. The FSM stays in the top.
// TESTING
//  op0 a=[1,2,3] b=[10,20,30] len3, zero-wait -> dst=[11,22,33], done at cycle 14
//  op1 a=[0] b=[1] len1 -> dst=[16'hFFFF]; ready low for 2 cycles on RD_B -> done 2 cycles later
//  op4 a=[5,6,7] b=[5,9,7] -> eq_all=0, no writes; with EARLY_EXIT, exactly 4 reads
//  len=0 start -> done pulse 2 cycles after start, mem_req never asserted
//  base_d=16'hFFFF len2 -> writes to FFFF then 0000; start while busy is ignored
//  rst_n low during WR -> mem_req=0 asynchronously, no done pulse, next command runs cleanly

Source files
------------

// File: rtl/vseq_pkg.sv
// Shared constants for the vector ALU sequencer: FSM state encoding and ALU op codes.
package vseq_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [3:0] OP_ADD       = 4'd0;
    localparam logic [3:0] OP_SUB       = 4'd1;
    localparam logic [3:0] OP_AND       = 4'd2;
    localparam logic [3:0] OP_OR        = 4'd3;
    localparam logic [3:0] OP_CMP       = 4'd4;
    localparam logic [3:0] OP_MAX_VALID = OP_CMP;

    function automatic logic is_mem_state(input logic [2:0] s);
        return (s == S_RD_A) || (s == S_RD_B) || (s == S_WR);
    endfunction

endpackage

// File: rtl/vseq_addr_gen.sv
// Base-address and element-counter bookkeeping; presents the addresses that will be
// valid in the next cycle so the top can register its memory request.
module vseq_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] base_a_i,
    input  logic [ADDR_W-1:0] base_b_i,
    input  logic [ADDR_W-1:0] base_d_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] nxt_addr_a_o,
    output logic [ADDR_W-1:0] nxt_addr_b_o,
    output logic [ADDR_W-1:0] nxt_addr_d_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic [ADDR_W-1:0] base_d_q, base_d_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;

    // Next-state for bases and element index (load wins over increment)
    always_comb begin
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_d_d = base_d_q;
        len_d    = len_q;
        idx_d    = idx_q;
        if (load_i) begin
            base_a_d = base_a_i;
            base_b_d = base_b_i;
            base_d_d = base_d_i;
            len_d    = len_i;
            idx_d    = {LEN_W{1'b0}};
        end else if (inc_i) begin
            idx_d = idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            idx_d = idx_q;
        end
    end

    // Address sums wrap naturally modulo 2^ADDR_W
    assign nxt_addr_a_o = base_a_d + ADDR_W'(idx_d);
    assign nxt_addr_b_o = base_b_d + ADDR_W'(idx_d);
    assign nxt_addr_d_o = base_d_d + ADDR_W'(idx_d);
    assign last_o = (({1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_q});

    // Counter and base registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_a_q <= {ADDR_W{1'b0}};
            base_b_q <= {ADDR_W{1'b0}};
            base_d_q <= {ADDR_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            idx_q    <= {LEN_W{1'b0}};
        end else begin
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_d_q <= base_d_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Memory-to-memory vector sequencer driving an external 16-bit ALU: dst[i] = A[i] op B[i].
// Optional feature: define VSEQ_EARLY_EXIT_EN to stop a compare on the first unequal pair.
module vec_alu_sequencer
    import vseq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              eq_all,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero
);

    logic [2:0]        state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, eq_all_q, eq_all_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wdata_q, wdata_d;
    logic [3:0]        op_q, op_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_s, inc_s, last_s;
    logic [ADDR_W-1:0] nxt_a_s, nxt_b_s, nxt_d_s;

    vseq_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_s),
        .inc_i        (inc_s),
        .base_a_i     (base_a),
        .base_b_i     (base_b),
        .base_d_i     (base_d),
        .len_i        (len),
        .nxt_addr_a_o (nxt_a_s),
        .nxt_addr_b_o (nxt_b_s),
        .nxt_addr_d_o (nxt_d_s),
        .last_o       (last_s)
    );

    // Sequencer FSM and datapath register next-state
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        eq_all_d = eq_all_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        load_s   = 1'b0;
        inc_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_s   = 1'b1;
                    op_d     = op;
                    eq_all_d = 1'b1;
                    busy_d   = 1'b1;
                    // Unsupported ops complete like an empty vector
                    if ((len == {LEN_W{1'b0}}) || (op > OP_MAX_VALID)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RD_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A: begin
                if (mem_ready) begin
                    a_d     = mem_rdata;
                    state_d = S_RD_B;
                end else begin
                    state_d = S_RD_A;
                end
            end
            S_RD_B: begin
                if (mem_ready) begin
                    b_d     = mem_rdata;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_RD_B;
                end
            end
            S_EXEC: begin
                wdata_d = alu_out;
                if (op_q == OP_CMP) begin
                    eq_all_d = eq_all_q & alu_zero;
`ifdef VSEQ_EARLY_EXIT_EN
                    if (!alu_zero || last_s) begin
`else
                    if (last_s) begin
`endif
                        state_d = S_FIN;
                    end else begin
                        inc_s   = 1'b1;
                        state_d = S_RD_A;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (mem_ready && last_s) begin
                    state_d = S_FIN;
                end else if (mem_ready) begin
                    inc_s   = 1'b1;
                    state_d = S_RD_A;
                end else begin
                    state_d = S_WR;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Memory request for the upcoming state, registered so outputs are glitch-free
    always_comb begin
        req_d = is_mem_state(state_d);
        we_d  = (state_d == S_WR);
        case (state_d)
            S_RD_A:  addr_d = nxt_a_s;
            S_RD_B:  addr_d = nxt_b_s;
            S_WR:    addr_d = nxt_d_s;
            default: addr_d = addr_q;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_all_q <= 1'b1;
            a_q      <= {DATA_W{1'b0}};
            b_q      <= {DATA_W{1'b0}};
            op_q     <= 4'd0;
            wdata_q  <= {DATA_W{1'b0}};
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            eq_all_q <= eq_all_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign eq_all    = eq_all_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

endmodule
